// File: rtl/hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects and FSM states.
package hazard_controller_pkg;

  localparam int unsigned RegAddrW = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMemWait = 2'b01,
    StErr     = 2'b10
  } state_e;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller bundle; master is the pipeline, slave is the controller.
interface hazard_controller_if
  import hazard_controller_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);
  logic [RegAddrW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic                result_src_e, pcsrc_e, reg_write_m, mem_req_m, dmem_ready, reg_write_w;
  logic [1:0]          forward_a_e, forward_b_e;
  logic                stall_f, stall_d, stall_e, stall_m;
  logic                flush_d, flush_e, flush_w;
  logic                mem_err;
  logic [CNT_W-1:0]    stall_cnt, flush_cnt;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output result_src_e, pcsrc_e, reg_write_m, mem_req_m, dmem_ready, reg_write_w,
    input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, flush_w, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  result_src_e, pcsrc_e, reg_write_m, mem_req_m, dmem_ready, reg_write_w,
    output forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, flush_w, mem_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_controller_forward_unit.sv
// Execute-stage operand forwarding select for one ALU source; Memory beats Writeback, x0 never forwards.
module hazard_controller_forward_unit
  import hazard_controller_pkg::*;
(
  input  logic [RegAddrW-1:0] i_rs_e,
  input  logic [RegAddrW-1:0] i_rd_m,
  input  logic                i_reg_write_m,
  input  logic [RegAddrW-1:0] i_rd_w,
  input  logic                i_reg_write_w,
  output fwd_sel_e            o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_reg_write_m && (i_rd_m != '0) && (i_rd_m == i_rs_e)) begin
      o_sel = FWD_M;
    end else if (i_reg_write_w && (i_rd_w != '0) && (i_rd_w == i_rs_e)) begin
      o_sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// 5-stage pipeline hazard controller: forwarding, load-use stall, branch flush,
// data-memory wait freeze with timeout trap, and saturating stall/flush counters.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  hazard_controller_if.slave io_hc
);

  localparam int unsigned        WaitW      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0]   TimeoutVal = WaitW'(MEM_TIMEOUT);

  state_e             r_state_q, r_state_d;
  logic [WaitW-1:0]   r_wait_q, r_wait_d;
  logic               r_err_q, r_err_d;
  logic [CNT_W-1:0]   r_stall_cnt_q, r_stall_cnt_d;
  logic [CNT_W-1:0]   r_flush_cnt_q, r_flush_cnt_d;

  fwd_sel_e           w_fwd_a, w_fwd_b;
  logic               w_mem_wait, w_load_use, w_branch;
  logic               w_freeze, w_lu_stall, w_flush_d, w_flush_e;
  logic [WaitW-1:0]   w_wait_inc;

  hazard_controller_forward_unit u_fwd_a (
    .i_rs_e       (io_hc.rs1_e),
    .i_rd_m       (io_hc.rd_m),
    .i_reg_write_m(io_hc.reg_write_m),
    .i_rd_w       (io_hc.rd_w),
    .i_reg_write_w(io_hc.reg_write_w),
    .o_sel        (w_fwd_a)
  );

  hazard_controller_forward_unit u_fwd_b (
    .i_rs_e       (io_hc.rs2_e),
    .i_rd_m       (io_hc.rd_m),
    .i_reg_write_m(io_hc.reg_write_m),
    .i_rd_w       (io_hc.rd_w),
    .i_reg_write_w(io_hc.reg_write_w),
    .o_sel        (w_fwd_b)
  );

  assign w_mem_wait = io_hc.mem_req_m & ~io_hc.dmem_ready;
  assign w_branch   = io_hc.pcsrc_e;
  assign w_load_use = io_hc.result_src_e && (io_hc.rd_e != '0) &&
                      ((io_hc.rd_e == io_hc.rs1_d) || (io_hc.rd_e == io_hc.rs2_d));
  assign w_wait_inc = (r_state_q == StRun) ? WaitW'(1) : r_wait_q + 1'b1;

  always_comb begin
    r_state_d  = r_state_q;
    r_wait_d   = r_wait_q;
    r_err_d    = r_err_q;
    w_freeze   = 1'b0;
    w_lu_stall = 1'b0;
    w_flush_d  = 1'b0;
    w_flush_e  = 1'b0;
    case (r_state_q)
      StRun, StMemWait: begin
        // Once waiting, only DMemReady releases the freeze.
        if ((r_state_q == StRun) ? w_mem_wait : !io_hc.dmem_ready) begin
          w_freeze  = 1'b1;
          r_wait_d  = w_wait_inc;
          r_state_d = StMemWait;
          if (w_wait_inc >= TimeoutVal) begin
            r_state_d = StErr;
            r_err_d   = 1'b1;
          end
        end else begin
          r_state_d = StRun;
          r_wait_d  = '0;
          if (w_branch) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
          end else if (w_load_use) begin
            w_lu_stall = 1'b1;
            w_flush_e  = 1'b1;
          end
        end
      end
      StErr:   w_freeze = 1'b1;
      default: r_state_d = StRun;
    endcase
  end

  always_comb begin
    r_stall_cnt_d = r_stall_cnt_q;
    r_flush_cnt_d = r_flush_cnt_q;
    if (r_state_q != StErr) begin
      if ((w_freeze || w_lu_stall) && (r_stall_cnt_q != '1)) r_stall_cnt_d = r_stall_cnt_q + 1'b1;
      if (w_flush_e && (r_flush_cnt_q != '1))                r_flush_cnt_d = r_flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state_q     <= StRun;
      r_wait_q      <= '0;
      r_err_q       <= 1'b0;
      r_stall_cnt_q <= '0;
      r_flush_cnt_q <= '0;
    end else begin
      r_state_q     <= r_state_d;
      r_wait_q      <= r_wait_d;
      r_err_q       <= r_err_d;
      r_stall_cnt_q <= r_stall_cnt_d;
      r_flush_cnt_q <= r_flush_cnt_d;
    end
  end

  // Control outputs are forced quiet for the whole time reset is held.
  assign io_hc.forward_a_e = i_rst_n ? w_fwd_a : FWD_RF;
  assign io_hc.forward_b_e = i_rst_n ? w_fwd_b : FWD_RF;
  assign io_hc.stall_f     = i_rst_n & (w_freeze | w_lu_stall);
  assign io_hc.stall_d     = i_rst_n & (w_freeze | w_lu_stall);
  assign io_hc.stall_e     = i_rst_n & w_freeze;
  assign io_hc.stall_m     = i_rst_n & w_freeze;
  assign io_hc.flush_w     = i_rst_n & w_freeze;
  assign io_hc.flush_d     = i_rst_n & w_flush_d;
  assign io_hc.flush_e     = i_rst_n & w_flush_e;
  assign io_hc.mem_err     = r_err_q;
  assign io_hc.stall_cnt   = r_stall_cnt_q;
  assign io_hc.flush_cnt   = r_flush_cnt_q;

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline controller for the 5-stage RISC-V core; sits beside Fetch/Decode/Execute/Memory/Writeback and sequences them.
- Generates the Execute-stage forwarding selects, load-use stalls, branch flushes and a data-memory wait freeze.
- Has a timeout state machine that traps a hung memory, plus saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 16, number of consecutive memory-wait cycles after which the controller enters ERR.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous reset, active-low
- RS1_D  in  5  rs1 of the instruction in Decode
- RS2_D  in  5  rs2 of the instruction in Decode
- RS1_E  in  5  rs1 of the instruction in Execute
- RS2_E  in  5  rs2 of the instruction in Execute
- RD_E  in  5  rd of the instruction in Execute
- ResultSrcE  in  1  Execute instruction is a load
- PCSrcE  in  1  branch/jump taken, resolved in Execute
- RD_M  in  5  rd in Memory
- RegWriteM  in  1  Memory instruction writes the register file
- MemReqM  in  1  Memory stage issues a load or store
- DMemReady  in  1  data memory completes the request this cycle
- RD_W  in  5  rd in Writeback
- RegWriteW  in  1  Writeback instruction writes the register file
- ForwardAE  out  2  source A select: 00 register file, 10 ALUResultM, 01 ResultW
- ForwardBE  out  2  source B select, same encoding
- StallF, StallD, StallE, StallM  out  1 each  hold the stage register
- FlushD, FlushE  out  1 each  clear the stage register to a bubble
- FlushW  out  1  insert a bubble into Writeback
- MemErr  out  1  sticky memory-timeout flag
- StallCnt  out  CNT_W  cycles with StallF asserted, saturating
- FlushCnt  out  CNT_W  cycles with FlushE asserted, saturating

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN, wait counter=0, MemErr=0, StallCnt=0, FlushCnt=0.
  - All stall/flush outputs and forwarding selects are forced to 0 while rst=0.
- Forwarding (combinational), evaluated separately for A (RS1_E) and B (RS2_E):
  - Select 10 if RegWriteM, RD_M!=0 and RD_M==RSx_E.
  - Otherwise select 01 if RegWriteW, RD_W!=0 and RD_W==RSx_E.
  - Otherwise select 00.
  - Memory always has priority over Writeback; register x0 is never forwarded.
- Load-use condition: ResultSrcE, RD_E!=0, and RD_E equals RS1_D or RS2_D.
- Branch condition: PCSrcE.
- Mem-wait condition: MemReqM and not DMemReady.
- States: RUN, MEM_WAIT, ERR.
- RUN:
  - If mem-wait: StallF=StallD=StallE=StallM=1 and FlushW=1; go to MEM_WAIT with wait counter=1. Load-use and branch outputs are suppressed, and the branch is applied after release because E is held.
  - Else if branch: FlushD=FlushE=1, no stall. Branch beats load-use because the dependent instruction is squashed.
  - Else if load-use: StallF=StallD=1 and FlushE=1 for exactly one cycle; the load then advances to M and forwarding covers the dependency.
- MEM_WAIT:
  - Same freeze outputs as mem-wait in RUN.
  - When DMemReady=1: outputs follow RUN rules for that cycle (freeze released), state goes to RUN, counter clears.
  - Otherwise the counter increments; when the counter reaches MEM_TIMEOUT, go to ERR and set MemErr=1.
- ERR:
  - All stalls and FlushW are held at 1, FlushD=FlushE=0.
  - Only reset exits ERR; MemErr stays set until reset.
- Counters:
  - StallCnt increments on every cycle StallF=1; FlushCnt increments on every cycle FlushE=1.
  - Both saturate at all-ones and do not count while in ERR.
- Reset asserted mid-wait or in ERR clears everything immediately; the first cycle after release is in RUN.

Decomposition:
- Shared package holds the forwarding encodings (FWD_RF=00, FWD_W=01, FWD_M=10) and the state encodings RUN/MEM_WAIT/ERR.
- One sub-module, forward_unit, contains the combinational select logic and is instantiated once per ALU source.

Test Plan:
- Forwarding priority: RD_M=5 and RD_W=5, both with RegWrite=1, RS1_E=5 -> ForwardAE=10; deassert RegWriteM -> ForwardAE=01; RS1_E=0 with RD_M=0 -> ForwardAE=00.
- Load-use: ResultSrcE=1, RD_E=3, RS2_D=3 -> StallF=StallD=FlushE=1 for one cycle; StallCnt=1, FlushCnt=1.
- Branch over load-use: same as the load-use case plus PCSrcE=1 -> FlushD=FlushE=1, StallF=0.
- Memory wait: MemReqM=1, DMemReady=0 for 3 cycles, then 1 -> StallF..StallM and FlushW=1 for 3 cycles, released on the 4th; state ends in RUN; MemErr=0.
- Timeout: MEM_TIMEOUT=4, DMemReady held at 0 -> ERR after the 4th wait cycle, MemErr=1; asserting DMemReady later changes nothing; rst=0 clears MemErr and both counters.
- Reset mid-wait: drive rst low during MEM_WAIT -> all outputs 0 immediately; after rst=1 with no request, no stall is asserted.
